// File: rtl/dp_step_tracer.sv
// Datapath single-step tracer: runs the datapath for N enabled cycles and
// records {alu_out, muxb_out} per executed cycle into a FWFT trace FIFO.
module dp_step_tracer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_req,
    input  logic [CNT_W-1:0]      step_n,
    input  logic                  stall_on_full,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic [DATA_W-1:0]     muxb_out,
    output logic                  dp_ce,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [2*DATA_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                  overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [LVL_W-1:0]   level_q;
    logic               ovf_q;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full = (level_q == LVL_W'(DEPTH));
    assign pop  = rd_valid && rd_ready;

    // Step sequencing; a full FIFO only blocks the push when nothing drains this cycle
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dp_ce   = 1'b0;
        push    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (step_req) begin
                    if (step_n != CNT_W'(0)) begin
                        rem_d   = step_n;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RUN: begin
                if (full && !pop && stall_on_full) begin
                    state_d = S_HOLD;
                end else begin
                    dp_ce = 1'b1;
                    if (!full || pop) begin
                        push = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_HOLD: begin
                if (!full || !stall_on_full) begin
                    state_d = S_RUN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // FIFO bookkeeping; storage itself needs no reset since rd_data is gated by rd_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= {alu_out, muxb_out};
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign rd_valid = (level_q != LVL_W'(0));
    assign rd_data  = rd_valid ? mem[rptr_q] : '0;
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_dp_step_tracer.sv
// Directed bench for dp_step_tracer with a queue scoreboard of expected trace entries.
module tb_dp_step_tracer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   step_req;
    logic [CNT_W-1:0]       step_n;
    logic                   stall_on_full;
    logic [DATA_W-1:0]      alu_out;
    logic [DATA_W-1:0]      muxb_out;
    logic                   dp_ce;
    logic                   busy;
    logic                   done;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [2*DATA_W-1:0]    rd_data;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;

    dp_step_tracer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .step_req      (step_req),
        .step_n        (step_n),
        .stall_on_full (stall_on_full),
        .alu_out       (alu_out),
        .muxb_out      (muxb_out),
        .dp_ce         (dp_ce),
        .busy          (busy),
        .done          (done),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .level         (level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb_q [$];
    int  mdl_level = 0;
    logic mdl_ovf = 1'b0;

    int cycno = 0;
    int nce, ndone, nbusy, nread, ndrop;
    int first_ce, last_ce, done_cyc, req_cyc;
    logic seen_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic reset_counters();
        nce = 0; ndone = 0; nbusy = 0; nread = 0; ndrop = 0;
        first_ce = -1; last_ce = -1; done_cyc = -1;
        seen_done = 1'b0;
    endtask

    // One clock: score outputs at the falling edge, then return just after the rising edge
    task automatic cyc();
        logic pop, push, ce;
        logic [63:0] want;
        @(negedge clk);
        cycno++;
        chk("level", 64'(level), 64'(mdl_level));
        chk("rd_valid", 64'(rd_valid), 64'(mdl_level != 0));
        chk("overflow", 64'(overflow), 64'(mdl_ovf));
        pop  = (mdl_level != 0) && rd_ready;
        push = 1'b0;
        ce   = dp_ce;
        if (pop) begin
            want = sb_q.pop_front();
            chk("rd_data", rd_data, want);
            nread++;
        end
        if (ce) begin
            if (nce == 0) first_ce = cycno;
            last_ce = cycno;
            nce++;
            if (mdl_level < int'(DEPTH) || pop) begin
                sb_q.push_back({alu_out, muxb_out});
                push = 1'b1;
            end else begin
                ndrop++;
                mdl_ovf = 1'b1;
            end
        end
        if (done) begin
            ndone++;
            done_cyc  = cycno;
            seen_done = 1'b1;
        end
        if (busy) nbusy++;
        mdl_level = mdl_level + int'(push) - int'(pop);
        @(posedge clk);
        #1;
        if (ce) begin
            alu_out  = alu_out + 32'h10;
            muxb_out = muxb_out + 32'h1;
        end
    endtask

    task automatic start(input int n);
        step_req = 1'b1;
        step_n   = CNT_W'(n);
        cyc();
        req_cyc  = cycno;
        step_req = 1'b0;
    endtask

    task automatic run_until_done(input int max_cyc);
        for (int i = 0; i < max_cyc && !seen_done; i++) cyc();
        chk("done_timeout", 64'(seen_done), 64'd1);
    endtask

    task automatic drain(input int max_cyc);
        rd_ready = 1'b1;
        for (int i = 0; i < max_cyc && mdl_level != 0; i++) cyc();
        chk("drain_level", 64'(level), 64'd0);
    endtask

    initial begin
        rst = 1'b0; step_req = 1'b0; step_n = '0; stall_on_full = 1'b1;
        alu_out = 32'h10; muxb_out = 32'hA0; rd_ready = 1'b0;
        reset_counters();
        #3;
        chk("rst_dp_ce", 64'(dp_ce), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        cyc(); cyc();
        rst = 1'b1;

        // Three steps with an always-ready consumer
        rd_ready = 1'b1; stall_on_full = 1'b1;
        alu_out = 32'h10; muxb_out = 32'hA0;
        reset_counters();
        start(3);
        run_until_done(20);
        drain(20);
        cyc(); cyc();
        chk("t1_nce", 64'(nce), 64'd3);
        chk("t1_first_ce", 64'(first_ce), 64'(req_cyc + 1));
        chk("t1_done_cyc", 64'(done_cyc), 64'(req_cyc + 4));
        chk("t1_done_after_last", 64'(done_cyc - last_ce), 64'd1);
        chk("t1_ndone", 64'(ndone), 64'd1);
        chk("t1_nread", 64'(nread), 64'd3);

        // Zero-length request
        reset_counters();
        start(0);
        cyc(); cyc();
        chk("t2_nce", 64'(nce), 64'd0);
        chk("t2_done_cyc", 64'(done_cyc), 64'(req_cyc + 1));
        chk("t2_ndone", 64'(ndone), 64'd1);
        chk("t2_nbusy", 64'(nbusy), 64'd1);

        // Stall on full, then release the consumer
        rd_ready = 1'b0; stall_on_full = 1'b1;
        reset_counters();
        start(20);
        repeat (20) cyc();
        chk("t3_nce_hold", 64'(nce), 64'd16);
        chk("t3_dp_ce_hold", 64'(dp_ce), 64'd0);
        chk("t3_busy_hold", 64'(busy), 64'd1);
        chk("t3_level_hold", 64'(level), 64'd16);
        chk("t3_no_done", 64'(seen_done), 64'd0);
        rd_ready = 1'b1;
        run_until_done(100);
        drain(40);
        chk("t3_nce", 64'(nce), 64'd20);
        chk("t3_nread", 64'(nread), 64'd20);
        chk("t3_ndrop", 64'(ndrop), 64'd0);
        chk("t3_overflow", 64'(overflow), 64'd0);

        // Drop mode: keep stepping while full
        rd_ready = 1'b0; stall_on_full = 1'b0;
        reset_counters();
        start(20);
        run_until_done(40);
        chk("t4_nce", 64'(nce), 64'd20);
        chk("t4_consecutive", 64'(last_ce - first_ce), 64'd19);
        chk("t4_done_cyc", 64'(done_cyc), 64'(req_cyc + 21));
        chk("t4_level", 64'(level), 64'd16);
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_ndrop", 64'(ndrop), 64'd4);
        drain(40);
        chk("t4_nread", 64'(nread), 64'd16);

        // Full FIFO with simultaneous pop keeps running at level 16
        rd_ready = 1'b0; stall_on_full = 1'b1;
        reset_counters();
        start(24);
        for (int i = 0; i < 40 && level != 16; i++) cyc();
        chk("t5_full", 64'(level), 64'd16);
        rd_ready = 1'b1;
        repeat (4) cyc();
        chk("t5_level_hold", 64'(level), 64'd16);
        chk("t5_dp_ce", 64'(dp_ce), 64'd1);
        run_until_done(60);
        chk("t5_nce", 64'(nce), 64'd24);
        chk("t5_consecutive", 64'(last_ce - first_ce), 64'd23);
        chk("t5_ndrop", 64'(ndrop), 64'd0);
        drain(40);
        chk("t5_nread", 64'(nread), 64'd24);

        // Asynchronous reset in the middle of a run
        rd_ready = 1'b0; stall_on_full = 1'b1;
        reset_counters();
        start(10);
        for (int i = 0; i < 20 && nce < 5; i++) cyc();
        chk("t6_level_pre", 64'(level), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_dp_ce", 64'(dp_ce), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_rd_valid", 64'(rd_valid), 64'd0);
        chk("t6_level", 64'(level), 64'd0);
        sb_q.delete();
        mdl_level = 0;
        mdl_ovf   = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        chk("t6_no_done", 64'(ndone), 64'd0);
        reset_counters();
        rd_ready = 1'b1;
        start(2);
        run_until_done(20);
        drain(20);
        chk("t6_nce", 64'(nce), 64'd2);
        chk("t6_ndone", 64'(ndone), 64'd1);
        chk("t6_nread", 64'(nread), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dp_step_tracer.md
Name: dp_step_tracer

Overview:
- On-chip counterpart of the datapath bench stimulus. It single-steps the datapath through a clock enable (`dp_ce`), N instructions per request.
- Each executed cycle, it captures `{alu_out, MUXB_OUT}` into a trace FIFO.
- A host/debug port drains the FIFO over a valid/ready stream.
- Sits between the debug interface and the datapath top.

Parameters:
- DATA_W, 32, width of each captured datapath bus.
- DEPTH, 16, trace FIFO entries; power of two, ≥ 2.
- CNT_W, 8, width of the step counter / step request.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- step_req  in  1  start pulse; sampled only in IDLE
- step_n  in  CNT_W  number of instructions to execute; latched with step_req
- stall_on_full  in  1  1 = pause stepping when FIFO full; 0 = keep stepping and drop samples
- alu_out  in  DATA_W  datapath ALU result
- muxb_out  in  DATA_W  datapath ALU B-operand mux output
- dp_ce  out  1  datapath clock enable; the datapath executes one instruction per cycle with dp_ce=1
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when a step request completes
- rd_valid  out  1  trace head valid
- rd_ready  in  1  consumer accepts head
- rd_data  out  2*DATA_W  {alu_out, muxb_out} at the head
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a sample was dropped

Behaviour:
- Reset (rst=0, async): state=IDLE, dp_ce=0, busy=0, done=0, rd_valid=0, level=0, overflow=0, FIFO pointers=0, rd_data=0.
- States: IDLE, RUN, HOLD, FIN.
- IDLE:
  - step_req=1 and step_n≠0: latch remaining=step_n, go to RUN.
  - step_req=1 and step_n=0: go to FIN (done pulses, no dp_ce).
  - step_req outside IDLE: ignored.
- RUN:
  - dp_ce=1 combinationally this cycle.
  - At the edge: push {alu_out, muxb_out} (values present before that edge) and decrement remaining.
  - remaining reaches 0: go to FIN.
- Full handling:
  - In RUN, if the FIFO is full, no pop occurs this cycle, and stall_on_full=1: dp_ce=0, go to HOLD, no decrement.
  - If stall_on_full=0: dp_ce stays 1, the sample is dropped, overflow←1, decrement proceeds.
- HOLD:
  - dp_ce=0.
  - Return to RUN the cycle after the FIFO is not full.
  - stall_on_full falling to 0 in HOLD also returns to RUN.
- FIN: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, HOLD and FIN.
- Latency: step_req at edge k → first dp_ce cycle is k+1. N steps with no stalls → done asserted in cycle k+N+1.
- FIFO:
  - Push permitted when level<DEPTH, or when a pop happens in the same cycle (full + simultaneous pop = push and pop, level unchanged).
  - Pop when rd_valid&&rd_ready.
  - rd_valid = (level≠0). rd_data = head, first-word-fall-through, stable while rd_valid&&!rd_ready.
  - Pointers wrap modulo DEPTH. level never exceeds DEPTH.
  - Pop on empty: no effect.
- overflow clears only on reset.
- Reset mid-RUN or mid-HOLD: immediate IDLE, dp_ce=0, FIFO emptied, no done pulse.

Test Plan:
- Reset, then step_req with step_n=3, rd_ready=1, alu_out=0x10,0x20,0x30 on successive dp_ce cycles:
  - dp_ce high exactly 3 cycles, done one cycle after the last.
  - rd_data sequence {0x10,..},{0x20,..},{0x30,..}; level returns to 0.
- step_n=0:
  - No dp_ce; done pulses one cycle after the request; busy high for exactly one cycle.
- DEPTH=16, rd_ready=0, stall_on_full=1, step_n=20:
  - 16 dp_ce cycles, then HOLD with level=16 and dp_ce=0.
  - Raise rd_ready: remaining 4 steps complete, 20 entries read in order, overflow=0.
- Same as above but stall_on_full=0:
  - 20 consecutive dp_ce cycles; entries 17–20 dropped; overflow=1; level=16.
  - Reads return samples 1–16.
- FIFO full with rd_ready=1 during RUN:
  - Push and pop in the same cycle; level holds at 16; no HOLD entry.
- rst=0 asserted asynchronously mid-clock-cycle during RUN with level=5:
  - dp_ce, busy, rd_valid, level all 0 immediately.
  - No done pulse; a new step_req after release works normally.
